// File: rtl/sextium_mem_loader_pkg.sv
// Shared definitions for the Sextium memory loader: data widths, the loader
// state encoding and the byte-pair packing helper.
package sextium_mem_loader_pkg;

   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;

   // IDLE waits for a start pulse, BYTE0/BYTE1 collect the two halves of a
   // word from the byte stream, WRITE holds the word on the bus until the
   // slave accepts it, and FINISH raises the one-cycle completion pulse.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BYTE0  = 3'd1,
      BYTE1  = 3'd2,
      WRITE  = 3'd3,
      FINISH = 3'd4
   } loaderState_e;

   // Combines the first and second byte of a pair into one word. With
   // bigEndian set the byte that arrived first becomes the upper half,
   // otherwise it becomes the lower half.
   function automatic logic [WORD_W-1:0] packBytes(
      input logic [BYTE_W-1:0] firstByte,
      input logic [BYTE_W-1:0] secondByte,
      input logic              bigEndian
   );
      logic [WORD_W-1:0] word;
      word = '0;
      if (bigEndian) begin
         word = {firstByte, secondByte};
      end else begin
         word = {secondByte, firstByte};
      end
      return word;
   endfunction

endpackage

// File: rtl/sextium_byte_packer.sv
// Pairs bytes from the loader's input stream into 16-bit words. It keeps the
// first byte of a pair and presents the assembled word while the second byte
// is on the stream, so the loader can register it on the consuming cycle.
module sextium_byte_packer
   import sextium_mem_loader_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              storeFirst_i,
   input  logic [BYTE_W-1:0] dataIn_i,
   output logic [WORD_W-1:0] word_o
);

   logic [BYTE_W-1:0] firstByte_q;
   logic [BYTE_W-1:0] firstByte_d;

   // The held byte only changes when the loader tells us the byte on the
   // stream is the first half of a new pair; otherwise it keeps its value so
   // the second byte can be combined with it whenever that byte shows up.
   always_comb begin
      firstByte_d = firstByte_q;
      if (storeFirst_i) begin
         firstByte_d = dataIn_i;
      end
   end

   // Register for the held first byte, cleared by the asynchronous reset so
   // an abandoned load leaves no stale half-word behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         firstByte_q <= '0;
      end else begin
         firstByte_q <= firstByte_d;
      end
   end

   // The word is formed from the held byte and whatever byte is currently on
   // the stream; the loader decides when that combination is meaningful.
   always_comb begin
      word_o = packBytes(firstByte_q, dataIn_i, BIG_ENDIAN);
   end

endmodule

// File: rtl/sextium_mem_loader.sv
// Loads a block of 16-bit words into memory over Avalon-MM from an 8-bit
// valid/ready byte stream, keeping the CPU in reset until the first load has
// finished.
module sextium_mem_loader
   import sextium_mem_loader_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] base_addr,
   input  logic [WORD_W-1:0] length,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] avm_address,
   output logic [1:0]        avm_byteenable,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [WORD_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold
);

   loaderState_e      state_q;
   loaderState_e      state_d;
   logic [WORD_W-1:0] addrCount_q;
   logic [WORD_W-1:0] addrCount_d;
   logic [WORD_W-1:0] remaining_q;
   logic [WORD_W-1:0] remaining_d;
   logic [WORD_W-1:0] writeData_q;
   logic [WORD_W-1:0] writeData_d;
   logic              seenDone_q;
   logic              seenDone_d;
   logic              storeFirst;
   logic [WORD_W-1:0] packedWord;

   sextium_byte_packer #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) uPacker (
      .clk          (clk),
      .reset        (reset),
      .storeFirst_i (storeFirst),
      .dataIn_i     (in_data),
      .word_o       (packedWord)
   );

   // Next-state and output decode for the loader. Everything defaults to the
   // idle, bus-quiet values first so each state only spells out what it
   // changes. Bytes are only taken in BYTE0/BYTE1 and the bus is only driven
   // in WRITE, which keeps stream consumption and bus writes in separate
   // cycles. The address and word count move only when the slave accepts a
   // write, so a stalled write keeps address, data and strobes steady.
   always_comb begin
      state_d        = state_q;
      addrCount_d    = addrCount_q;
      remaining_d    = remaining_q;
      writeData_d    = writeData_q;
      storeFirst     = 1'b0;
      in_ready       = 1'b0;
      avm_chipselect = 1'b0;
      avm_write      = 1'b0;
      avm_byteenable = 2'b00;
      busy           = 1'b1;
      done           = 1'b0;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (length == '0) begin
                  state_d = FINISH;
               end else begin
                  addrCount_d = base_addr;
                  remaining_d = length;
                  state_d     = BYTE0;
               end
            end
         end

         BYTE0: begin
            in_ready = 1'b1;
            if (in_valid) begin
               storeFirst = 1'b1;
               state_d    = BYTE1;
            end
         end

         BYTE1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               writeData_d = packedWord;
               state_d     = WRITE;
            end
         end

         WRITE: begin
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_byteenable = 2'b11;
            if (!avm_waitrequest) begin
               addrCount_d = addrCount_q + 16'd1;
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  state_d = FINISH;
               end else begin
                  state_d = BYTE0;
               end
            end
         end

         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Remembers whether any load has completed since reset. Until then the CPU
   // is kept in reset unconditionally; afterwards it is only held while a
   // load is running.
   always_comb begin
      seenDone_d = seenDone_q;
      if (state_q == FINISH) begin
         seenDone_d = 1'b1;
      end
   end

   // State, counters and the outgoing data word. The reset is asynchronous so
   // a load, even one parked on a stalled write, is dropped immediately and
   // all bus strobes fall without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addrCount_q <= '0;
         remaining_q <= '0;
         writeData_q <= '0;
         seenDone_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addrCount_q <= addrCount_d;
         remaining_q <= remaining_d;
         writeData_q <= writeData_d;
         seenDone_q  <= seenDone_d;
      end
   end

   // The bus address always reflects the address counter, the write data is
   // the registered word, and the CPU hold follows the rule described above.
   always_comb begin
      avm_address   = addrCount_q;
      avm_writedata = writeData_q;
      cpu_hold      = (!seenDone_q) || busy;
   end

endmodule

// File: tb/tb_sextium_mem_loader.sv
// Bench for the Sextium memory loader. Two loaders, one big-endian and one
// little-endian, share the same stimulus and are compared every cycle against
// a transaction-level model of the load, with hand-computed write lists for
// each directed case.
module tb_sextium_mem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] baseAddr = '0;
   logic [15:0] lengthIn = '0;
   logic [7:0]  inData = '0;
   logic        inValid = 1'b0;
   logic        waitReq = 1'b0;

   logic        inReadyBe, csBe, wrBe, busyBe, doneBe, holdBe;
   logic [15:0] addrBe, wdBe;
   logic [1:0]  benBe;
   logic        inReadyLe, csLe, wrLe, busyLe, doneLe, holdLe;
   logic [15:0] addrLe, wdLe;
   logic [1:0]  benLe;

   int errors = 0;
   int checks = 0;
   bit checkEnable = 1'b0;

   bit          mActive, mFinish, mHalf, mWritePending, mEverDone;
   logic [15:0] mAddr, mLeft, mWordBe, mWordLe;
   logic [7:0]  mFirst;

   logic [15:0] logAddr[$];
   logic [15:0] logBe[$];
   logic [15:0] logLe[$];
   int doneCount = 0;
   int writeHighCount = 0;

   sextium_mem_loader #(.BIG_ENDIAN(1'b1)) dutBe (
      .clk(clk), .reset(reset), .start(start), .base_addr(baseAddr), .length(lengthIn),
      .in_data(inData), .in_valid(inValid), .in_ready(inReadyBe),
      .avm_address(addrBe), .avm_byteenable(benBe), .avm_chipselect(csBe),
      .avm_write(wrBe), .avm_writedata(wdBe), .avm_waitrequest(waitReq),
      .busy(busyBe), .done(doneBe), .cpu_hold(holdBe)
   );

   sextium_mem_loader #(.BIG_ENDIAN(1'b0)) dutLe (
      .clk(clk), .reset(reset), .start(start), .base_addr(baseAddr), .length(lengthIn),
      .in_data(inData), .in_valid(inValid), .in_ready(inReadyLe),
      .avm_address(addrLe), .avm_byteenable(benLe), .avm_chipselect(csLe),
      .avm_write(wrLe), .avm_writedata(wdLe), .avm_waitrequest(waitReq),
      .busy(busyLe), .done(doneLe), .cpu_hold(holdLe)
   );

   always #5 clk = ~clk;

   // Compares one observed value against its expected value and reports any
   // difference on a single line.
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%04h expected=0x%04h at %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction-level model of a load: a load is either inactive, finishing,
   // waiting for bytes (counting halves of the current pair) or holding a
   // word for the bus. Words are formed directly from the byte pair in both
   // byte orders.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mActive <= 1'b0; mFinish <= 1'b0; mHalf <= 1'b0; mWritePending <= 1'b0;
         mEverDone <= 1'b0; mAddr <= '0; mLeft <= '0; mWordBe <= '0; mWordLe <= '0;
         mFirst <= '0;
      end else if (mFinish) begin
         mFinish <= 1'b0;
         mEverDone <= 1'b1;
      end else if (!mActive) begin
         if (start) begin
            if (lengthIn == 16'd0) begin
               mFinish <= 1'b1;
            end else begin
               mActive <= 1'b1; mAddr <= baseAddr; mLeft <= lengthIn; mHalf <= 1'b0;
            end
         end
      end else if (mWritePending) begin
         if (!waitReq) begin
            mAddr <= mAddr + 16'd1;
            mLeft <= mLeft - 16'd1;
            mWritePending <= 1'b0;
            if (mLeft == 16'd1) begin
               mActive <= 1'b0;
               mFinish <= 1'b1;
            end
         end
      end else if (inValid) begin
         if (!mHalf) begin
            mFirst <= inData;
            mHalf <= 1'b1;
         end else begin
            mHalf <= 1'b0;
            mWordBe <= {mFirst, inData};
            mWordLe <= {inData, mFirst};
            mWritePending <= 1'b1;
         end
      end
   end

   // Every cycle, away from the active edge, both loaders are compared with
   // the model, and accepted writes and done pulses are logged for the
   // per-case write lists.
   always @(negedge clk) begin
      if (checkEnable) begin
         checkOutput("beReady", 16'(inReadyBe), 16'(mActive && !mWritePending));
         checkOutput("beWrite", 16'(wrBe), 16'(mWritePending));
         checkOutput("beCs", 16'(csBe), 16'(mWritePending));
         checkOutput("beBen", 16'(benBe), mWritePending ? 16'd3 : 16'd0);
         checkOutput("beAddr", addrBe, mAddr);
         checkOutput("beData", wdBe, mWordBe);
         checkOutput("beBusy", 16'(busyBe), 16'(mActive || mFinish));
         checkOutput("beDone", 16'(doneBe), 16'(mFinish));
         checkOutput("beHold", 16'(holdBe), 16'(!mEverDone || mActive || mFinish));
         checkOutput("leReady", 16'(inReadyLe), 16'(mActive && !mWritePending));
         checkOutput("leWrite", 16'(wrLe), 16'(mWritePending));
         checkOutput("leBen", 16'(benLe), mWritePending ? 16'd3 : 16'd0);
         checkOutput("leAddr", addrLe, mAddr);
         checkOutput("leData", wdLe, mWordLe);
         checkOutput("leDone", 16'(doneLe), 16'(mFinish));
         checkOutput("leHold", 16'(holdLe), 16'(!mEverDone || mActive || mFinish));
      end
      if (!reset) begin
         if (wrBe) writeHighCount++;
         if (doneBe) doneCount++;
         if (wrBe && !waitReq) begin
            logAddr.push_back(addrBe);
            logBe.push_back(wdBe);
            logLe.push_back(wdLe);
         end
      end
   end

   task automatic clearLog();
      logAddr.delete(); logBe.delete(); logLe.delete();
      doneCount = 0;
      writeHighCount = 0;
   endtask

   // Pulses start for one cycle with the given base address and length.
   task automatic applyStimulus(input logic [15:0] base, input logic [15:0] len);
      @(posedge clk); #2;
      start = 1'b1; baseAddr = base; lengthIn = len;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   // Offers one byte and holds it until the loader has taken it.
   task automatic pushByte(input logic [7:0] b);
      bit taken;
      taken = 1'b0;
      inData = b;
      inValid = 1'b1;
      for (int i = 0; i < 60 && !taken; i++) begin
         @(negedge clk);
         if (inReadyBe) begin
            @(posedge clk); #2;
            taken = 1'b1;
         end
      end
      inValid = 1'b0;
      if (!taken) checkOutput("pushTimeout", 16'd0, 16'd1);
   endtask

   // Waits for the done pulse, then one further cycle into idle.
   task automatic waitDone();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (doneBe) seen = 1'b1;
      end
      if (!seen) checkOutput("doneTimeout", 16'd0, 16'd1);
      @(negedge clk);
   endtask

   // Waits until a write is on the bus.
   task automatic waitWrite();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (wrBe) seen = 1'b1;
      end
      if (!seen) checkOutput("writeTimeout", 16'd0, 16'd1);
   endtask

   task automatic checkWrite(input string name, input int idx, input logic [15:0] expAddr,
                             input logic [15:0] expBe, input logic [15:0] expLe);
      if (idx < logAddr.size()) begin
         checkOutput({name, "Addr"}, logAddr[idx], expAddr);
         checkOutput({name, "Be"}, logBe[idx], expBe);
         checkOutput({name, "Le"}, logLe[idx], expLe);
      end else begin
         checkOutput({name, "Missing"}, 16'(logAddr.size()), 16'(idx + 1));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      checkEnable = 1'b1;
      checkOutput("rstReady", 16'(inReadyBe), 16'd0);
      checkOutput("rstWrite", 16'(wrBe), 16'd0);
      checkOutput("rstBen", 16'(benBe), 16'd0);
      checkOutput("rstBusy", 16'(busyBe), 16'd0);
      checkOutput("rstHold", 16'(holdBe), 16'd1);
      checkOutput("rstData", wdBe, 16'h0000);
      reset = 1'b0;

      $display("[TB] case: two words from 0x0010, both byte orders, ignored restart");
      clearLog();
      applyStimulus(16'h0010, 16'd2);
      pushByte(8'h12);
      pushByte(8'h34);
      applyStimulus(16'h0040, 16'd5);
      pushByte(8'h56);
      pushByte(8'h78);
      waitDone();
      checkOutput("aCount", 16'(logAddr.size()), 16'd2);
      checkWrite("aW0", 0, 16'h0010, 16'h1234, 16'h3412);
      checkWrite("aW1", 1, 16'h0011, 16'h5678, 16'h7856);
      checkOutput("aDoneCount", 16'(doneCount), 16'd1);
      checkOutput("aHoldAfter", 16'(holdBe), 16'd0);

      $display("[TB] case: first write stalled for three cycles");
      clearLog();
      waitReq = 1'b1;
      applyStimulus(16'h0100, 16'd2);
      pushByte(8'hAA);
      pushByte(8'hBB);
      waitWrite();
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #2;
      waitReq = 1'b0;
      pushByte(8'hCC);
      pushByte(8'hDD);
      waitDone();
      checkOutput("bWriteCycles", 16'(writeHighCount), 16'd5);
      checkWrite("bW0", 0, 16'h0100, 16'hAABB, 16'hBBAA);
      checkWrite("bW1", 1, 16'h0101, 16'hCCDD, 16'hDDCC);

      $display("[TB] case: address wrap from 0xFFFF");
      clearLog();
      applyStimulus(16'hFFFF, 16'd2);
      pushByte(8'h01);
      pushByte(8'h02);
      pushByte(8'h03);
      pushByte(8'h04);
      waitDone();
      checkWrite("cW0", 0, 16'hFFFF, 16'h0102, 16'h0201);
      checkWrite("cW1", 1, 16'h0000, 16'h0304, 16'h0403);
      checkOutput("cAddrAfter", addrBe, 16'h0001);

      $display("[TB] case: zero-length load with start during finish");
      clearLog();
      @(posedge clk); #2;
      start = 1'b1; baseAddr = 16'h0050; lengthIn = 16'd0;
      @(posedge clk); #2;
      baseAddr = 16'h0060; lengthIn = 16'd1;
      @(negedge clk);
      checkOutput("dDoneNow", 16'(doneBe), 16'd1);
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("dDoneCount", 16'(doneCount), 16'd1);
      checkOutput("dWriteCycles", 16'(writeHighCount), 16'd0);
      checkOutput("dAddrKept", addrBe, 16'h0001);
      checkOutput("dBusyAfter", 16'(busyBe), 16'd0);

      $display("[TB] case: reset during a stalled write, then a fresh load");
      clearLog();
      waitReq = 1'b1;
      applyStimulus(16'h0200, 16'd1);
      pushByte(8'h5A);
      pushByte(8'hA5);
      waitWrite();
      @(negedge clk);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      checkOutput("eRstWrite", 16'(wrBe), 16'd0);
      checkOutput("eRstCs", 16'(csBe), 16'd0);
      checkOutput("eRstBen", 16'(benBe), 16'd0);
      checkOutput("eRstReady", 16'(inReadyBe), 16'd0);
      checkOutput("eRstBusy", 16'(busyBe), 16'd0);
      checkOutput("eRstDone", 16'(doneBe), 16'd0);
      checkOutput("eRstHold", 16'(holdBe), 16'd1);
      checkOutput("eRstData", wdBe, 16'h0000);
      checkOutput("eRstAddr", addrBe, 16'h0000);
      @(posedge clk); #2;
      reset = 1'b0;
      waitReq = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("eNoDone", 16'(doneCount), 16'd0);
      checkOutput("eNoWrite", 16'(logAddr.size()), 16'd0);
      clearLog();
      applyStimulus(16'h0020, 16'd1);
      pushByte(8'hAB);
      pushByte(8'hCD);
      waitDone();
      checkOutput("eCount", 16'(logAddr.size()), 16'd1);
      checkWrite("eW0", 0, 16'h0020, 16'hABCD, 16'hCDAB);
      checkOutput("eDoneCount", 16'(doneCount), 16'd1);
      checkOutput("eHoldAfter", 16'(holdBe), 16'd0);

      checkEnable = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
